// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the CYC1000 LED sequencer: register map, mode encoding, CTRL fields.
package led_ctrl_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_DATA     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_DUTY_LO  = 3'd4;
  localparam logic [2:0] ADDR_DUTY_HI  = 3'd5;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    BLINK  = 2'd1,
    SCROLL = 2'd2,
    BOUNCE = 2'd3
  } led_mode_t;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_MODE_MSB = 1;
  localparam int unsigned CTRL_EN_BIT   = 8;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts while enabled and emits a one-cycle tick when the count reaches period.
module led_tick_gen #(
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || clr || (cnt == period)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

  assign tick = en && (cnt == period);

endmodule

// File: rtl/cyc1000_led_ctrl.sv
// Avalon-MM LED sequencer (direct/blink/scroll/bounce) for the CYC1000 board.
// Optional per-LED PWM brightness is built when LED_PWM_EN is defined.
module cyc1000_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned LED_W        = 8,
  parameter int unsigned PRESCALE_RST = 11_999_999,
  parameter int unsigned PRESCALE_W   = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [LED_W-1:0] led
);

  led_mode_t             mode_q;
  logic                  en_q;
  logic [LED_W-1:0]      data_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick_seen;
  logic [LED_W-1:0]      pattern_q, pattern_d;
  logic [LED_W-1:0]      snap_q, snap_d;
  logic                  dir_left_q, dir_left_d;
  logic                  blink_off_q, blink_off_d;
  logic [31:0]           rd_mux;

  logic wr_ctrl, wr_data, wr_pre, rd_status, entry, tick_raw, tick;
  led_mode_t        wr_mode;
  logic [LED_W-1:0] data_nxt;

  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_data   = avs_write && (avs_address == ADDR_DATA);
  assign wr_pre    = avs_write && (avs_address == ADDR_PRESCALE);
  assign rd_status = avs_read  && (avs_address == ADDR_STATUS);
  assign wr_mode   = led_mode_t'(avs_writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
  assign entry     = wr_ctrl && avs_writedata[CTRL_EN_BIT] && (!en_q || (wr_mode != mode_q));
  // A CTRL write in the same cycle as a tick swallows that tick.
  assign tick      = tick_raw && !wr_ctrl;
  assign data_nxt  = wr_data ? avs_writedata[LED_W-1:0] : data_q;

  led_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (en_q),
    .clr    (wr_pre || entry),
    .period (prescale_q),
    .tick   (tick_raw)
  );

`ifdef LED_PWM_EN
  logic [8*LED_W-1:0] duty_q;
  logic [7:0]         pwm_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q     <= DIRECT;
      en_q       <= 1'b0;
      data_q     <= '0;
      prescale_q <= PRESCALE_W'(PRESCALE_RST);
      tick_seen  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        mode_q <= wr_mode;
        en_q   <= avs_writedata[CTRL_EN_BIT];
      end
      data_q <= data_nxt;
      if (wr_pre) prescale_q <= avs_writedata[PRESCALE_W-1:0];
      tick_seen <= tick || (tick_seen && !rd_status);
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      duty_q  <= '1;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (avs_write && (avs_address == ADDR_DUTY_LO)) duty_q[31:0]  <= avs_writedata;
      if (avs_write && (avs_address == ADDR_DUTY_HI)) duty_q[63:32] <= avs_writedata;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:24];
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:     begin
        rd_mux[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        rd_mux[CTRL_EN_BIT]                 = en_q;
      end
      ADDR_DATA:     rd_mux[LED_W-1:0] = data_q;
      ADDR_PRESCALE: rd_mux[PRESCALE_W-1:0] = prescale_q;
      ADDR_STATUS:   rd_mux = {23'd0, tick_seen, pattern_q};
`ifdef LED_PWM_EN
      ADDR_DUTY_LO:  rd_mux = duty_q[31:0];
      ADDR_DUTY_HI:  rd_mux = duty_q[63:32];
`endif
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)        avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_q   <= '0;
      snap_q      <= '0;
      dir_left_q  <= 1'b1;
      blink_off_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      snap_q      <= snap_d;
      dir_left_q  <= dir_left_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Sequencer next state: mode entry beats everything, then DIRECT tracking, then tick steps
  always_comb begin
    pattern_d   = pattern_q;
    snap_d      = snap_q;
    dir_left_d  = dir_left_q;
    blink_off_d = blink_off_q;
    if (entry) begin
      snap_d      = data_nxt;
      blink_off_d = 1'b0;
      dir_left_d  = 1'b1;
      pattern_d   = (wr_mode == BOUNCE) ? LED_W'(1) : data_nxt;
    end else if (en_q && !wr_ctrl) begin
      if (mode_q == DIRECT) begin
        pattern_d = data_nxt;
      end else if (tick) begin
        case (mode_q)
          BLINK: begin
            pattern_d   = blink_off_q ? snap_q : '0;
            blink_off_d = !blink_off_q;
          end
          SCROLL: pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
          BOUNCE: begin
            if (dir_left_q) begin
              if (pattern_q[LED_W-1]) begin
                dir_left_d = 1'b0;
                pattern_d  = pattern_q >> 1;
              end else begin
                pattern_d  = pattern_q << 1;
              end
            end else begin
              if (pattern_q[0]) begin
                dir_left_d = 1'b1;
                pattern_d  = pattern_q << 1;
              end else begin
                pattern_d  = pattern_q >> 1;
              end
            end
          end
          default: pattern_d = pattern_q;
        endcase
      end
    end
  end

  // Sequencer output
`ifdef LED_PWM_EN
  always_comb begin
    led = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      led[i] = en_q && pattern_q[i] && (pwm_cnt < duty_q[8*i +: 8]);
    end
  end
`else
  always_comb begin
    led = en_q ? pattern_q : '0;
  end
`endif

endmodule
